// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB elastic stage.
// It provides the occupancy encodings, the payload width and the offsets used
// to pack and unpack the payload fields.
// Payload layout, from MSB to LSB: {reg_write, wb_data[XLEN-1:0], rd[REG_ADDR_W-1:0]}
package mem_wb_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    localparam int XLEN_DEFAULT       = 64;
    localparam int REG_ADDR_W_DEFAULT = 5;
    localparam int WB_PAYLOAD_W       = 1 + XLEN_DEFAULT + REG_ADDR_W_DEFAULT;

    function automatic int wb_payload_w(input int xlen, input int reg_addr_w);
        return 1 + xlen + reg_addr_w;
    endfunction

    function automatic int off_rd();
        return 0;
    endfunction

    function automatic int off_wb_data(input int reg_addr_w);
        return reg_addr_w;
    endfunction

    function automatic int off_reg_write(input int xlen, input int reg_addr_w);
        return xlen + reg_addr_w;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready stage whose payload width is set by a parameter.
// SKID=1 gives a 2-entry skid buffer with a registered in_ready.
// SKID=0 gives a single entry with a combinational in_ready.
//
// Ports:
//   clk, reset            : clock and asynchronous active-high reset
//   flush                 : synchronous discard of every held entry
//   in_valid/in_ready     : upstream handshake, in_data is the payload
//   out_valid/out_ready   : downstream handshake, out_data is the payload
//   occupancy             : number of entries held (0..2)
//
// state     | meaning
// ----------+-----------------------------------------------
// OCC_EMPTY | nothing held
// OCC_ONE   | main holds the output entry
// OCC_TWO   | main holds output, skid holds overflow entry
module pipe_skid_buf #(
    parameter int W    = 8,
    parameter bit SKID = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);
    import mem_wb_pkg::*;

    occ_e         state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_ready_q, in_ready_d;
    logic         accept, release_w;

    assign out_valid = (state_q != OCC_EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign in_ready  = SKID ? in_ready_q : (~out_valid | out_ready);
    assign accept    = in_valid & in_ready;
    assign release_w = out_valid & out_ready;

    // With SKID=0 an accept in OCC_ONE always coincides with a release,
    // so OCC_TWO is never reached and the same transition table serves both modes.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            unique case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        state_d = OCC_ONE;
                        main_d  = in_data;
                    end
                end
                OCC_ONE: begin
                    if (accept && release_w) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = OCC_TWO;
                        skid_d  = in_data;
                    end else if (release_w) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (release_w) begin
                        state_d = OCC_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
        in_ready_d = (state_d != OCC_TWO);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= OCC_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB elastic pipeline stage placed between the data-memory stage and the
// register-file write port.
// The write-back data is selected at capture time. Writes to x0 are suppressed
// when the entry is stored. A saturating counter records back-pressure cycles.
//
// Ports:
//   clk, reset                 : clock and asynchronous active-high reset
//   flush                      : synchronous discard of held entries
//   in_valid/in_ready          : MEM-side handshake
//   in_reg_write, in_mem_to_reg, in_read_data, in_alu_result, in_rd : MEM payload
//   out_valid/out_ready        : write-back handshake
//   out_reg_write, out_wb_data, out_rd : write-back payload
//   occupancy                  : entries held (0..2)
//   stall_cycles               : saturating count of out_valid & ~out_ready cycles
module mem_wb_pipe #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5,
    parameter bit SKID       = 1'b1,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_reg_write,
    input  logic                  in_mem_to_reg,
    input  logic [XLEN-1:0]       in_read_data,
    input  logic [XLEN-1:0]       in_alu_result,
    input  logic [REG_ADDR_W-1:0] in_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_reg_write,
    output logic [XLEN-1:0]       out_wb_data,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [1:0]            occupancy,
    output logic [CNT_W-1:0]      stall_cycles
);
    import mem_wb_pkg::*;

    localparam int PW      = wb_payload_w(XLEN, REG_ADDR_W);
    localparam int OFF_RD  = off_rd();
    localparam int OFF_DAT = off_wb_data(REG_ADDR_W);
    localparam int OFF_RW  = off_reg_write(XLEN, REG_ADDR_W);

    logic [PW-1:0]    in_payload, out_payload;
    logic [CNT_W-1:0] stall_q, stall_d;

    assign in_payload[OFF_RW]                 = in_reg_write & (in_rd != '0);
    assign in_payload[OFF_DAT +: XLEN]        = in_mem_to_reg ? in_read_data : in_alu_result;
    assign in_payload[OFF_RD +: REG_ADDR_W]   = in_rd;

    pipe_skid_buf #(
        .W    (PW),
        .SKID (SKID)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload),
        .occupancy (occupancy)
    );

    // The stored write enable may be stale after a flush, so it is gated by out_valid.
    assign out_reg_write = out_payload[OFF_RW] & out_valid;
    assign out_wb_data   = out_payload[OFF_DAT +: XLEN];
    assign out_rd        = out_payload[OFF_RD +: REG_ADDR_W];

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && !(&stall_q)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
Parametrised MEM/WB pipeline stage for the pipelined RISC-V core. It replaces the free-running stage register with a valid/ready elastic stage, built as a 2-entry skid buffer. It adds synchronous flush, x0 write suppression, write-back data selection at capture, occupancy status and a saturating back-pressure counter. It sits between the data-memory stage and the register-file write port.

Parameters:
XLEN, 64, datapath width of read data, ALU result and write-back data
REG_ADDR_W, 5, destination register index width
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
CNT_W, 32, width of stall_cycles counter

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous flush; discards all held entries
in_valid  input  1  MEM stage presents an instruction
in_ready  output  1  stage can accept this cycle
in_reg_write  input  1  instruction writes the register file
in_mem_to_reg  input  1  1 = write back read data, 0 = ALU result
in_read_data  input  XLEN  data-memory read data
in_alu_result  input  XLEN  ALU result
in_rd  input  REG_ADDR_W  destination register
out_valid  output  1  write-back entry valid
out_ready  input  1  write-back consumer accepts
out_reg_write  output  1  qualified write enable (stored reg_write AND out_valid)
out_wb_data  output  XLEN  selected write-back data
out_rd  output  REG_ADDR_W  destination register
occupancy  output  2  entries held (0..2)
stall_cycles  output  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-high.
- Reset values: occupancy=0, out_valid=0, out_reg_write=0, out_wb_data=0, out_rd=0, stall_cycles=0. in_ready=1 (SKID=1 and SKID=0).
- Handshakes:
  - Accept: in_valid & in_ready. Release: out_valid & out_ready.
- Capture rules:
  - Stored wb_data = in_mem_to_reg ? in_read_data : in_alu_result, muxed at capture; mem_to_reg itself is not stored.
  - Stored reg_write = in_reg_write & (in_rd != 0). An x0 write never asserts out_reg_write.
- Latency: an accepted entry appears at the outputs on the next cycle (1 cycle). Payload is in-order, never duplicated, and never dropped except by flush.
- SKID=1 state machine, with states named by occupancy (main = output entry, skid = overflow entry):
  - EMPTY: accept -> ONE (main<=in).
  - ONE:
    - accept & release -> ONE (main<=in).
    - accept & no release -> TWO (skid<=in).
    - release & no accept -> EMPTY.
  - TWO: in_ready=0. Release -> ONE (main<=skid). No release -> hold.
  - in_ready is a register: next value = (next occupancy != 2).
- SKID=0:
  - Single entry. in_ready = ~out_valid | out_ready (combinational).
  - occupancy never exceeds 1.
- flush (highest priority, synchronous):
  - Next cycle: occupancy=0, out_valid=0, in_ready=1.
  - An input presented in the flush cycle is dropped.
  - A release in the flush cycle still counts as completed for the consumer.
  - Data registers need not clear; out_reg_write is 0 because it is qualified by out_valid.
- stall_cycles:
  - +1 each cycle out_valid & ~out_ready, including flush cycles.
  - Saturates at all-ones; cleared only by reset.
- Outputs hold stable while out_valid & ~out_ready (no payload change under back-pressure).
- Reset mid-operation: all entries lost immediately, asynchronously; outputs take reset values without waiting for a clock edge.

Decomposition:
- Shared package/header mem_wb_pkg:
  - Occupancy encodings OCC_EMPTY=0, OCC_ONE=1, OCC_TWO=2.
  - Payload width constant WB_PAYLOAD_W = 1 + XLEN + REG_ADDR_W.
  - Pack/unpack field offsets.
- One sub-module pipe_skid_buf: generic payload-width skid buffer with valid/ready, flush and the SKID mode switch. mem_wb_pipe wraps it and adds the write-back mux, x0 suppression, output qualification and the counter.

Test Plan:
- Streaming, no back-pressure:
  - Stimulus: out_ready=1; accept rd=5, alu=0x1234, mem_to_reg=0, reg_write=1.
  - Required: next cycle out_valid=1, out_rd=5, out_wb_data=0x1234, out_reg_write=1, occupancy=1.
- Memory select and x0 write:
  - Stimulus: rd=7, mem_to_reg=1, read_data=0xDEADBEEF.
  - Required: out_wb_data=0xDEADBEEF.
  - Stimulus: rd=0, reg_write=1.
  - Required: out_reg_write=0, out_valid=1.
- Skid fill and drain (SKID=1):
  - Stimulus: out_ready=0; accept A then B.
  - Required: occupancy=2, in_ready=0, outputs show A, stall_cycles increments each cycle.
  - Stimulus: out_ready=1.
  - Required: A released, then B, then occupancy=0. Order is A, B with no loss.
- Flush:
  - Stimulus: occupancy=2, flush=1 with in_valid=1 (entry C).
  - Required: next cycle occupancy=0, out_valid=0, in_ready=1; C never appears.
- Counter saturation: with CNT_W=4, hold a stall for 20 cycles -> stall_cycles=15.
- Async reset mid-stream:
  - Stimulus: assert reset between clock edges while occupancy=2.
  - Required: immediately out_valid=0, occupancy=0, stall_cycles=0.
  - SKID=0 variant: out_ready=0 with out_valid=1 gives in_ready=0 in the same cycle.
